// File: rtl/fix2bcd_conv.sv
// fix2bcd_conv: converts an unsigned INT_W.FRAC_W fixed-point value into
// BCD digits. The integer part uses shift-and-add-3, one bit per cycle.
// The fraction part uses repeated multiply-by-10, one digit per cycle.
module fix2bcd_conv #(
  parameter int unsigned INT_W       = 16,
  parameter int unsigned FRAC_W      = 24,
  parameter int unsigned INT_DIGITS  = 5,
  parameter int unsigned FRAC_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      conv_start,
  input  logic [INT_W+FRAC_W-1:0]   conv_din,
  input  logic                      conv_neg,
  input  logic                      conv_ovf,
  output logic                      conv_busy,
  output logic                      conv_done,
  output logic [4*INT_DIGITS-1:0]   int_bcd,
  output logic [4*FRAC_DIGITS-1:0]  frac_bcd,
  output logic                      sign_out,
  output logic                      err_out
);

  localparam int unsigned CNT_MAX = (INT_W > FRAC_DIGITS) ? INT_W : FRAC_DIGITS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INT,
    S_FRAC,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [INT_W-1:0]           int_sr_q, int_sr_d;
  logic [FRAC_W-1:0]          frac_sr_q, frac_sr_d;
  logic [4*INT_DIGITS-1:0]    bcd_q, bcd_d;
  logic [4*FRAC_DIGITS-1:0]   facc_q, facc_d;
  logic                       neg_q, neg_d;
  logic                       ovf_q, ovf_d;
  logic [4*INT_DIGITS-1:0]    int_bcd_q, int_bcd_d;
  logic [4*FRAC_DIGITS-1:0]   frac_bcd_q, frac_bcd_d;
  logic                       sign_q, sign_d;
  logic                       err_q, err_d;

  logic [4*INT_DIGITS-1:0]    adj;
  logic [3:0]                 nib;
  logic [FRAC_W+3:0]          prod;

  // State and datapath registers; everything clears on async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      int_sr_q   <= '0;
      frac_sr_q  <= '0;
      bcd_q      <= '0;
      facc_q     <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      int_bcd_q  <= '0;
      frac_bcd_q <= '0;
      sign_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_sr_q   <= int_sr_d;
      frac_sr_q  <= frac_sr_d;
      bcd_q      <= bcd_d;
      facc_q     <= facc_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
      int_bcd_q  <= int_bcd_d;
      frac_bcd_q <= frac_bcd_d;
      sign_q     <= sign_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: capture, integer double dabble, fraction digits, publish.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    int_sr_d   = int_sr_q;
    frac_sr_d  = frac_sr_q;
    bcd_d      = bcd_q;
    facc_d     = facc_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    int_bcd_d  = int_bcd_q;
    frac_bcd_d = frac_bcd_q;
    sign_d     = sign_q;
    err_d      = err_q;
    adj        = '0;
    nib        = '0;
    prod       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (conv_start) begin
          int_sr_d  = conv_din[FRAC_W +: INT_W];
          frac_sr_d = conv_din[FRAC_W-1:0];
          neg_d     = conv_neg;
          ovf_d     = conv_ovf;
          bcd_d     = '0;
          facc_d    = '0;
          cnt_d     = '0;
          if (conv_ovf) begin
            // Overflow reaches DONE on the capture edge, so the outputs are
            // published from the inputs here rather than from latched state.
            state_d    = S_DONE;
            int_bcd_d  = '1;
            frac_bcd_d = '1;
            sign_d     = conv_neg;
            err_d      = 1'b1;
          end else begin
            state_d = S_INT;
          end
        end
      end

      S_INT: begin
        for (int unsigned i = 0; i < INT_DIGITS; i++) begin
          nib = bcd_q[4*i +: 4];
          adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        bcd_d    = {adj[4*INT_DIGITS-2:0], int_sr_q[INT_W-1]};
        int_sr_d = {int_sr_q[INT_W-2:0], 1'b0};
        if (cnt_q == CNT_W'(INT_W - 1)) begin
          cnt_d   = '0;
          state_d = S_FRAC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FRAC: begin
        prod      = (FRAC_W+4)'(frac_sr_q) * (FRAC_W+4)'(10);
        frac_sr_d = prod[FRAC_W-1:0];
        facc_d    = {facc_q[4*FRAC_DIGITS-5:0], prod[FRAC_W+3:FRAC_W]};
        if (cnt_q == CNT_W'(FRAC_DIGITS - 1)) begin
          cnt_d      = '0;
          state_d    = S_DONE;
          int_bcd_d  = bcd_q;
          frac_bcd_d = facc_d;
          sign_d     = neg_q;
          err_d      = ovf_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign conv_busy = (state_q == S_INT) || (state_q == S_FRAC);
  assign conv_done = (state_q == S_DONE);
  assign int_bcd   = int_bcd_q;
  assign frac_bcd  = frac_bcd_q;
  assign sign_out  = sign_q;
  assign err_out   = err_q;

endmodule
